// File: rtl/tlb_pkg.sv
// tlb_pkg: shared op/state encodings and parity helpers for the TLB write path.
package tlb_pkg;
    localparam int NGROUPS_DEF = 2;
    typedef enum logic [1:0] {OP_FILL, OP_TBIS, OP_TBIA, OP_RSVD} op_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, SWEEP} state_t;
    function automatic logic tag_parity(input logic valid, input logic [14:0] tag);
        return ~^{valid, tag};
    endfunction
    // data_h holds PTE bits [23:4], so fields are [7:0], [15:8], [19:16] here
    function automatic logic [2:0] data_parity(input logic [19:0] data);
        return {~^data[19:16], ~^data[15:8], ~^data[7:0]};
    endfunction
endpackage

// File: rtl/tlb_parity_gen.sv
// tlb_parity_gen: odd tag and per-field data parity for the shared group write bus.
module tlb_parity_gen import tlb_pkg::*; (
    input  logic        valid,
    input  logic [14:0] tag,
    input  logic [19:0] data,
    output logic        tag_par,
    output logic [2:0]  data_par
);
    always_comb begin
        tag_par  = tag_parity(valid, tag);
        data_par = data_parity(data);
    end
endmodule

// File: rtl/tlb_fill_ctl.sv
// tlb_fill_ctl: write-side controller running TLB fill, TBIS and TBIA over the tlbgroup array pair.
module tlb_fill_ctl import tlb_pkg::*; #(
    parameter int NGROUPS    = NGROUPS_DEF,
    parameter int INIT_SWEEP = 1
) (
    input  logic               b_clk_l,
    input  logic               reset_h,
    input  logic               req_valid_h,
    input  logic [1:0]         req_op_h,
    input  logic [14:0]        req_tag_h,
    input  logic [7:0]         req_index_h,
    input  logic [19:0]        req_data_h,
    input  logic [NGROUPS-1:0] grp_hit_h,
    output logic               busy_h,
    output logic               done_h,
    output logic [7:0]         index_h,
    output logic [14:0]        in_tag_h,
    output logic               in_valid_h,
    output logic               tag_par_in_h,
    output logic [19:0]        data_h,
    output logic [2:0]         data_par_in_h,
    output logic [NGROUPS-1:0] write_h
);
    localparam int PW = NGROUPS > 1 ? $clog2(NGROUPS) : 1;
    state_t state;
    op_t op, rop;
    logic lk;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [NGROUPS-1:0] low_hit, fill_wr;
    always_comb begin
        rop     = op_t'(req_op_h);
        low_hit = grp_hit_h & (~grp_hit_h + NGROUPS'(1));
        ptr_nxt = (ptr == PW'(NGROUPS - 1)) ? '0 : ptr + PW'(1);
        fill_wr = |grp_hit_h ? low_hit : NGROUPS'(1) << ptr;
    end
    // lk marks the second lookup cycle, when the groups' hit outputs are valid
    always_ff @(posedge b_clk_l or posedge reset_h) begin
        if (reset_h) begin
            state      <= INIT_SWEEP != 0 ? SWEEP : IDLE;
            busy_h     <= INIT_SWEEP != 0;
            op         <= OP_FILL;
            lk         <= 1'b0;
            ptr        <= '0;
            done_h     <= 1'b0;
            write_h    <= '0;
            index_h    <= '0;
            in_tag_h   <= '0;
            in_valid_h <= 1'b0;
            data_h     <= '0;
        end else begin
            done_h     <= 1'b0;
            write_h    <= '0;
            in_valid_h <= 1'b0;
            case (state)
                IDLE: if (req_valid_h) begin
                    op       <= rop;
                    busy_h   <= 1'b1;
                    lk       <= 1'b0;
                    index_h  <= rop == OP_TBIA ? '0 : req_index_h;
                    in_tag_h <= req_op_h[1] ? '0 : req_tag_h;
                    data_h   <= rop == OP_FILL ? req_data_h : '0;
                    write_h  <= {NGROUPS{rop == OP_TBIA}};
                    done_h   <= rop == OP_RSVD;
                    state    <= req_op_h[1] ? (req_op_h[0] ? WRITE : SWEEP) : LOOKUP;
                end
                LOOKUP: begin
                    lk <= 1'b1;
                    if (lk) begin
                        state      <= WRITE;
                        done_h     <= 1'b1;
                        in_valid_h <= op == OP_FILL;
                        write_h    <= op == OP_FILL ? fill_wr : grp_hit_h;
                        if (op == OP_FILL && !(|grp_hit_h)) ptr <= ptr_nxt;
                    end
                end
                WRITE: begin
                    state  <= IDLE;
                    busy_h <= 1'b0;
                end
                SWEEP: begin
                    // write_h low here only for the post-reset start cycle
                    if (write_h[0] && index_h == 8'hff) begin
                        state   <= IDLE;
                        busy_h  <= 1'b0;
                        index_h <= '0;
                    end else begin
                        write_h <= '1;
                        index_h <= index_h + {7'd0, write_h[0]};
                        done_h  <= write_h[0] && index_h == 8'hfe;
                    end
                end
            endcase
        end
    end
    tlb_parity_gen u_par (
        .valid   (in_valid_h),
        .tag     (in_tag_h),
        .data    (data_h),
        .tag_par (tag_par_in_h),
        .data_par(data_par_in_h)
    );
endmodule

// File: tb/tb_tlb_fill_ctl.sv
// tb_tlb_fill_ctl: randomized bench with a per-operation expectation schedule and a tlbgroup write model.
module tb_tlb_fill_ctl;
    localparam int NG = 2;
    logic        b_clk_l = 0, reset_h = 1, req_valid_h = 0;
    logic [1:0]  req_op_h = 0;
    logic [14:0] req_tag_h = 0;
    logic [7:0]  req_index_h = 0;
    logic [19:0] req_data_h = 0;
    logic [1:0]  grp_hit_h = 0;
    logic        busy_h, done_h, in_valid_h, tag_par_in_h;
    logic [7:0]  index_h;
    logic [14:0] in_tag_h;
    logic [19:0] data_h;
    logic [2:0]  data_par_in_h;
    logic [1:0]  write_h;

    tlb_fill_ctl #(.NGROUPS(NG), .INIT_SWEEP(1)) dut (
        .b_clk_l(b_clk_l), .reset_h(reset_h), .req_valid_h(req_valid_h), .req_op_h(req_op_h),
        .req_tag_h(req_tag_h), .req_index_h(req_index_h), .req_data_h(req_data_h),
        .grp_hit_h(grp_hit_h), .busy_h(busy_h), .done_h(done_h), .index_h(index_h),
        .in_tag_h(in_tag_h), .in_valid_h(in_valid_h), .tag_par_in_h(tag_par_in_h),
        .data_h(data_h), .data_par_in_h(data_par_in_h), .write_h(write_h)
    );

    always #5 b_clk_l = ~b_clk_l;

    typedef struct {
        logic busy, done; logic [1:0] wr;
        logic ca, cd, cdat;
        logic [7:0] idx; logic [14:0] tag; logic v; logic [19:0] data;
    } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, rp = 0;
    bit chk_en = 0;
    logic [1:0] lw_write; logic lw_valid, lw_tpar; logic [2:0] lw_dpar;
    logic [39:0] gm [NG][256];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic void push(logic busy, logic done, logic [1:0] wr, logic ca, logic cd, logic cdat,
                                 logic [7:0] idx, logic [14:0] tag, logic v, logic [19:0] data);
        exp_t e;
        e = '{busy, done, wr, ca, cd, cdat, idx, tag, v, data};
        q.push_back(e);
    endfunction

    function automatic logic [2:0] odd3(logic [19:0] d);
        return {~^d[19:16], ~^d[15:8], ~^d[7:0]};
    endfunction

    function automatic logic [1:0] lowest(logic [1:0] h);
        for (int g = 0; g < NG; g++) if (h[g]) return 2'(1 << g);
        return 2'b00;
    endfunction

    always @(negedge b_clk_l) if (chk_en) begin
        exp_t e;
        if (q.size() > 0) e = q.pop_front();
        else e = '{0, 0, 2'b00, 0, 0, 0, 8'h0, 15'h0, 0, 20'h0};
        check("busy", busy_h, e.busy);
        check("done", done_h, e.done);
        check("write", write_h, e.wr);
        if (e.ca) begin
            check("index", index_h, e.idx);
            check("tag", in_tag_h, e.tag);
        end
        if (e.cd) begin
            check("valid", in_valid_h, e.v);
            check("tag_par", tag_par_in_h, ~^{e.v, e.tag});
        end
        if (e.cdat) begin
            check("data", data_h, e.data);
            check("data_par", data_par_in_h, odd3(e.data));
        end
        if (write_h != 0) begin
            lw_write = write_h; lw_valid = in_valid_h; lw_tpar = tag_par_in_h; lw_dpar = data_par_in_h;
        end
    end

    // tlbgroup storage: groups write in the clock low phase
    always @(negedge b_clk_l)
        for (int g = 0; g < NG; g++)
            if (write_h[g]) gm[g][index_h] <= {in_valid_h, in_tag_h, tag_par_in_h, data_h, data_par_in_h};

    task automatic init_sweep();
        reset_h = 0;
        rp = 0;
        push(1, 0, 2'b00, 1, 1, 1, 8'h0, 15'h0, 0, 20'h0);
        for (int i = 0; i < 256; i++) push(1, i == 255, 2'b11, 1, 1, 1, 8'(i), 15'h0, 0, 20'h0);
        chk_en = 1;
        repeat (257) @(posedge b_clk_l);
        #1;
    endtask

    task automatic do_op(input int op, input logic [14:0] tag, input logic [7:0] idx,
                         input logic [19:0] data, input logic [1:0] hit, input bit noise, input int cut);
        int len, n;
        logic [1:0] w;
        req_valid_h = 1; req_op_h = 2'(op); req_tag_h = tag; req_index_h = idx; req_data_h = data;
        grp_hit_h = hit;
        @(posedge b_clk_l);
        #1;
        len = 1;
        if (op < 2) begin
            w = op == 1 ? hit : (hit != 0 ? lowest(hit) : 2'(1 << rp));
            if (op == 0 && hit == 0) rp = (rp + 1) % NG;
            repeat (2) push(1, 0, 2'b00, 1, 0, 0, idx, tag, 0, 20'h0);
            push(1, 1, w, 1, 1, op == 0, idx, tag, op == 0, data);
            len = 3;
        end else if (op == 2) begin
            for (int i = 0; i < 256; i++) push(1, i == 255, 2'b11, 1, 1, 1, 8'(i), 15'h0, 0, 20'h0);
            len = 256;
        end else push(1, 1, 2'b00, 0, 0, 0, 8'h0, 15'h0, 0, 20'h0);
        n = cut > 0 ? cut : len;
        for (int c = 1; c <= n; c++) begin
            req_valid_h = noise;
            if (noise) begin
                req_op_h = 2'($urandom); req_tag_h = 15'($urandom); req_index_h = 8'($urandom);
            end
            if (c == 1) grp_hit_h = 2'($urandom);
            if (c == 2) grp_hit_h = hit;
            @(posedge b_clk_l);
            #1;
        end
        req_valid_h = 0;
    endtask

    initial begin
        repeat (3) @(posedge b_clk_l);
        #1;
        check("rst_busy", busy_h, 1'b1);
        check("rst_write", write_h, 2'b00);
        check("rst_done", done_h, 1'b0);
        check("rst_index", index_h, 8'h00);
        check("rst_tag", in_tag_h, 15'h0);
        check("rst_valid", in_valid_h, 1'b0);
        check("rst_data", data_h, 20'h0);
        check("rst_tpar", tag_par_in_h, 1'b1);
        check("rst_dpar", data_par_in_h, 3'b111);
        init_sweep();

        do_op(0, 15'h1234, 8'h05, 20'hABCDE, 2'b00, 0, 0);
        check("lit_fill1_wr", lw_write, 2'b01);
        check("lit_fill1_valid", lw_valid, 1'b1);
        check("lit_fill1_tpar", lw_tpar, 1'b1);
        check("lit_fill1_dpar", lw_dpar, 3'b101);
        do_op(0, 15'h0777, 8'h06, 20'h12345, 2'b00, 0, 0);
        check("lit_fill2_wr", lw_write, 2'b10);
        do_op(0, 15'h1234, 8'h05, 20'h00F0F, 2'b10, 0, 0);
        check("lit_hit_wr", lw_write, 2'b10);
        do_op(0, 15'h0042, 8'h07, 20'hFFFFF, 2'b00, 0, 0);
        check("lit_ptr_kept", lw_write, 2'b01);
        do_op(1, 15'h1234, 8'h05, 20'h0, 2'b11, 0, 0);
        check("lit_tbis_wr", lw_write, 2'b11);
        check("lit_tbis_valid", lw_valid, 1'b0);
        do_op(1, 15'h0999, 8'h09, 20'h0, 2'b00, 0, 0);
        do_op(3, 15'h0, 8'h0, 20'h0, 2'b00, 0, 0);
        do_op(0, 15'h2222, 8'h33, 20'h55555, 2'b00, 1, 0);

        for (int k = 0, nt = 0; k < 40; k++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op == 2 && nt++ >= 2) op = 0;
            do_op(op, 15'($urandom), 8'($urandom), 20'($urandom), 2'($urandom), 1'($urandom), 0);
        end

        for (int g = 0; g < NG; g++)
            for (int k = 0; k < 16; k++) begin
                logic [39:0] e;
                e = gm[g][$urandom_range(0, 255)];
                check("loop_tag_perr", ~^e[39:23], 1'b0);
                check("loop_dpar", {^{e[22:19], e[2]}, ^{e[18:11], e[1]}, ^{e[10:3], e[0]}}, 3'b111);
            end

        do_op(2, 15'h0, 8'h0, 20'h0, 2'b00, 0, 100);
        chk_en = 0;
        check("mid_index", index_h, 8'd100);
        check("mid_write", write_h, 2'b11);
        #1 reset_h = 1;
        #1;
        check("mid_rst_write", write_h, 2'b00);
        check("mid_rst_busy", busy_h, 1'b1);
        check("mid_rst_index", index_h, 8'h00);
        q.delete();
        @(posedge b_clk_l);
        #1;
        init_sweep();
        do_op(0, 15'h0101, 8'h10, 20'h0F0F0, 2'b00, 0, 0);
        check("post_rst_wr", lw_write, 2'b01);
        repeat (2) @(posedge b_clk_l);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
